// File: rtl/arb_out_fifo_pkg.sv
// Shared constants for the arbiter output FIFO and the units that instantiate it.
package arb_out_fifo_pkg;

  localparam int unsigned ARB_FIFO_DEPTH = 2;

endpackage

// File: rtl/arb_out_fifo_modn_counter.sv
// Modulo-N counter with synchronous clear; used for the FIFO head and tail pointers.
module modn_counter #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (en_i) begin
      r_count <= (r_count == W'(N - 1)) ? '0 : r_count + 1'b1;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/arb_out_fifo.sv
// Registered FIFO behind the two-way arbiter; ready_o comes from occupancy only, so the
// consumer's ready never reaches the requesters combinationally.
module arb_out_fifo
  import arb_out_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = ARB_FIFO_DEPTH,
  parameter int unsigned SRC_W  = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [DATA_W-1:0]          data_i,
  input  logic [SRC_W-1:0]           src_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [DATA_W-1:0]          data_o,
  output logic [SRC_W-1:0]           src_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [CntW-1:0]   r_count;
  logic [DEPTH-1:0]  r_ent_valid;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [SRC_W-1:0]  r_src  [DEPTH];

  logic [PtrW-1:0] w_head;
  logic [PtrW-1:0] w_tail;
  logic            w_push;
  logic            w_pop;

  assign ready_o = (r_count != CntW'(DEPTH));
  assign valid_o = (r_count != '0);
  // Flush wins over both handshakes, even though ready_o may read 1 that cycle.
  assign w_push  = valid_i && ready_o && !flush_i;
  assign w_pop   = valid_o && ready_i && !flush_i;

  modn_counter #(
    .N (DEPTH),
    .W (PtrW)
  ) u_head (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (w_pop),
    .clr_i   (flush_i),
    .count_o (w_head)
  );

  modn_counter #(
    .N (DEPTH),
    .W (PtrW)
  ) u_tail (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (w_push),
    .clr_i   (flush_i),
    .count_o (w_tail)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count <= '0;
    end else if (flush_i) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  // Push and pop never target the same slot: that needs count==0 or count==DEPTH.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ent_valid <= '0;
    end else if (flush_i) begin
      r_ent_valid <= '0;
    end else begin
      if (w_push) r_ent_valid[w_tail] <= 1'b1;
      if (w_pop)  r_ent_valid[w_head] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_data[w_tail] <= data_i;
      r_src[w_tail]  <= src_i;
    end
  end

  assign data_o  = r_data[w_head];
  assign src_o   = r_src[w_head];
  assign count_o = r_count;

`ifndef SYNTHESIS
  a_count_le_depth: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    r_count <= CntW'(DEPTH));

  a_head_valid_bit: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    valid_o == r_ent_valid[w_head]);

  a_in_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (valid_i && !ready_o && !flush_i) |=> (valid_i && $stable(data_i) && $stable(src_i)));

  a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (valid_o && !ready_i && !flush_i) |=> (valid_o && $stable(data_o) && $stable(src_o)));
`endif

endmodule

// File: tb/tb_arb_out_fifo.sv
// Bench for arb_out_fifo: a DEPTH=2 and a DEPTH=3 instance, each checked every cycle
// against an ordered-list model of a bounded queue.
module tb_arb_out_fifo;

  logic clk;
  logic rst_n;

  logic        v [2];
  logic        r [2];
  logic        f [2];
  logic [63:0] d [2];
  logic [0:0]  s [2];

  logic        vo [2];
  logic        ro [2];
  logic [63:0] dout [2];
  logic [0:0]  so [2];
  logic [1:0]  co [2];

  logic        vo_a, vo_b, ro_a, ro_b;
  logic [63:0] do_a, do_b;
  logic [0:0]  so_a, so_b;
  logic [1:0]  co_a, co_b;

  int errors = 0;
  int checks = 0;

  // Model: entry 0 of each list is the oldest item.
  int          cap [2];
  int          msz [2];
  logic [63:0] md  [2][16];
  logic [0:0]  ms  [2][16];
  logic        acc [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  arb_out_fifo #(
    .DATA_W (64),
    .DEPTH  (2),
    .SRC_W  (1)
  ) u_dut2 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (f[0]),
    .valid_i (v[0]),
    .ready_o (ro_a),
    .data_i  (d[0]),
    .src_i   (s[0]),
    .valid_o (vo_a),
    .ready_i (r[0]),
    .data_o  (do_a),
    .src_o   (so_a),
    .count_o (co_a)
  );

  arb_out_fifo #(
    .DATA_W (64),
    .DEPTH  (3),
    .SRC_W  (1)
  ) u_dut3 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (f[1]),
    .valid_i (v[1]),
    .ready_o (ro_b),
    .data_i  (d[1]),
    .src_i   (s[1]),
    .valid_o (vo_b),
    .ready_i (r[1]),
    .data_o  (do_b),
    .src_o   (so_b),
    .count_o (co_b)
  );

  always_comb begin
    vo[0] = vo_a; ro[0] = ro_a; dout[0] = do_a; so[0] = so_a; co[0] = co_a;
    vo[1] = vo_b; ro[1] = ro_b; dout[1] = do_b; so[1] = so_b; co[1] = co_b;
  end

  task automatic chk(input string tag, input int k, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk("count_o", k, 64'(co[k]), 64'(msz[k]));
      chk("valid_o", k, 64'(vo[k]), 64'(msz[k] != 0));
      chk("ready_o", k, 64'(ro[k]), 64'(msz[k] != cap[k]));
      if (msz[k] != 0) begin
        chk("data_o", k, dout[k], md[k][0]);
        chk("src_o", k, 64'(so[k]), 64'(ms[k][0]));
      end
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) msz[k] = 0;
  endtask

  // One clock: decide transfers from pre-edge model state, apply them, then compare.
  task automatic tick();
    logic pop [2];
    logic push [2];
    for (int k = 0; k < 2; k++) begin
      pop[k]  = (msz[k] != 0) && r[k] && !f[k];
      push[k] = v[k] && (msz[k] != cap[k]) && !f[k];
      acc[k]  = push[k];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (f[k]) begin
        msz[k] = 0;
      end else begin
        if (pop[k]) begin
          for (int i = 0; i < 15; i++) begin
            md[k][i] = md[k][i+1];
            ms[k][i] = ms[k][i+1];
          end
          msz[k]--;
        end
        if (push[k]) begin
          md[k][msz[k]] = d[k];
          ms[k][msz[k]] = s[k];
          msz[k]++;
        end
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      v[k] = 1'b0; r[k] = 1'b0; f[k] = 1'b0; d[k] = '0; s[k] = '0;
    end
  endtask

  task automatic drive(input int k, input logic vv, input logic [63:0] dd, input logic ss,
                       input logic rr, input logic ff);
    v[k] = vv; d[k] = dd; s[k] = ss; r[k] = rr; f[k] = ff;
  endtask

  initial begin
    cap[0] = 2;
    cap[1] = 3;
    model_clear();
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset held 3 cycles with ready_i toggling.
    for (int i = 0; i < 3; i++) begin
      r[0] = 1'(i); r[1] = 1'(i + 1);
      @(posedge clk);
      #1 check_all();
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r[0] = 1'(i); r[1] = 1'(i);
      tick();
    end

    // Single transfer on DEPTH=2.
    idle();
    drive(0, 1'b1, 64'hA5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    tick();

    // Fill and backpressure on DEPTH=2.
    drive(0, 1'b1, 64'h11, 1'b0, 1'b0, 1'b0);
    tick();
    drive(0, 1'b1, 64'h22, 1'b1, 1'b0, 1'b0);
    tick();
    drive(0, 1'b1, 64'h33, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    r[0] = 1'b1;
    tick();
    r[0] = 1'b0;
    tick();
    drive(0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();

    // Streaming through DEPTH=3: simultaneous push and pop every beat.
    idle();
    for (int i = 0; i < 10; i++) begin
      drive(1, 1'b1, 64'(i), 1'(i), 1'b1, 1'b0);
      tick();
    end
    drive(1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    tick();

    // Flush collision with two entries held on DEPTH=2.
    idle();
    drive(0, 1'b1, 64'h44, 1'b0, 1'b0, 1'b0);
    tick();
    drive(0, 1'b1, 64'h55, 1'b1, 1'b0, 1'b0);
    tick();
    drive(0, 1'b1, 64'h77, 1'b1, 1'b1, 1'b1);
    tick();
    drive(0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) tick();

    // Flush with one entry held, so ready_o reads 1 while the request is dropped.
    drive(0, 1'b1, 64'h66, 1'b0, 1'b0, 1'b0);
    tick();
    drive(0, 1'b1, 64'h78, 1'b1, 1'b0, 1'b1);
    tick();
    drive(0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    tick();

    // Asynchronous reset between edges while count is 2.
    drive(0, 1'b1, 64'h81, 1'b0, 1'b0, 1'b0);
    tick();
    drive(0, 1'b1, 64'h82, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    #3 rst_n = 1'b0;
    #1;
    model_clear();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b1, 64'h5A, 1'b1, 1'b0, 1'b0);
    tick();
    drive(0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    tick();

    // Random traffic; a request not accepted is held unchanged until it is.
    idle();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!(v[k] && !acc[k] && !f[k])) begin
          v[k] = 1'($urandom);
          d[k] = {$urandom, $urandom};
          s[k] = 1'($urandom);
        end
        r[k] = ($urandom_range(3) != 0) ? 1'($urandom) : 1'b0;
        f[k] = ($urandom_range(15) == 0);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
